// File: rtl/uart_tx_cke_if.sv
// ----------------------------------------------------------------------------
// uart_tx_cke_if
// Word handshake between a producer and the uart_tx_cke serialiser.
//   data  : payload word, sampled by the transmitter on handshake
//   valid : producer has a word waiting in data
//   ready : transmitter can take a word this cycle
// A handshake happens on a rising clock edge with valid and ready both high.
// Modports:
//   master : producer side (drives data/valid, observes ready)
//   slave  : transmitter side (observes data/valid, drives ready)
// ----------------------------------------------------------------------------
interface uart_tx_cke_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_cke.sv
// ----------------------------------------------------------------------------
// uart_tx_cke
// UART transmitter paced by an external bit-rate clock enable. One word is
// accepted per frame and sent as: start(0), DATA_BITS payload bits LSB first,
// optional parity bit, STOP_BITS stop bits(1). Every line symbol lasts exactly
// one cke period; a word accepted while idle waits in SYNC for the next cke
// so the start bit is always a full period long.
// Parameters:
//   DATA_BITS : payload bits per frame (5..9)
//   STOP_BITS : stop bits per frame (1 or 2)
//   PARITY    : 0 none, 1 even, 2 odd
// Ports:
//   clk   : system clock, rising edge
//   rst_  : asynchronous active-low reset, aborts any frame with tx high
//   cke   : one-cycle bit-rate enable pulse
//   bus   : word handshake (slave side: data/valid in, ready out)
//   tx    : registered serial line, idle high
//   busy  : a frame is pending or on the line (inverse of ready)
// ----------------------------------------------------------------------------
module uart_tx_cke #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          cke,
  uart_tx_cke_if.slave  bus,
  output logic          tx,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  // Counters are wide enough for their terminal count and never wrap.
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int SCW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
  localparam logic [SCW-1:0] STOP_LAST = SCW'(STOP_BITS - 1);
  localparam logic           PAR_ODD   = (PARITY == 2);

  state_e               state_q;
  logic                 tx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [SCW-1:0]       stop_cnt_q;
  logic                 par_q;
  logic                 idle;

  assign idle      = (state_q == IDLE);
  assign bus.ready = idle;
  assign busy      = ~idle;
  assign tx        = tx_q;

  // NOTE: every register here is written with <= so all state updates see the
  // pre-edge values of each other; a blocking = would make the result depend
  // on statement order and break the shift/count sequencing.
  // NOTE: the async reset clears all state, including the shift register and
  // counters, so a frame cut short by reset can never resume after release.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      par_q      <= 1'b0;
    end else begin
      case (state_q)
        // Handshake: ready is high only here, so valid alone completes it.
        // A cke in this same cycle is deliberately ignored.
        IDLE: begin
          if (bus.valid) begin
            shift_q <= bus.data;
            state_q <= SYNC;
          end
        end

        SYNC: begin
          if (cke) begin
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end

        // The shift register still holds the whole latched word here, so the
        // parity is taken from it rather than from the live input.
        START: begin
          if (cke) begin
            tx_q      <= shift_q[0];
            par_q     <= (^shift_q) ^ PAR_ODD;
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end

        DATA: begin
          if (cke) begin
            if (bit_cnt_q < BIT_LAST) begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (PARITY != 0) begin
              tx_q    <= par_q;
              state_q <= PAR;
            end else begin
              tx_q       <= 1'b1;
              stop_cnt_q <= '0;
              state_q    <= STOP;
            end
          end
        end

        PAR: begin
          if (cke) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= '0;
            state_q    <= STOP;
          end
        end

        STOP: begin
          if (cke) begin
            if (stop_cnt_q == STOP_LAST) begin
              state_q <= IDLE;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_cke.md
UART_TX_CKE -- requirements
Module: uart_tx_cke

Interface
REQ-001 Parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_  input  1  asynchronous, active-low reset.
REQ-006 cke  input  1  bit-rate enable, one-cycle pulse once per bit period, driven by the clock-enable generator.
REQ-007 data  input  DATA_BITS  payload, sampled on handshake.
REQ-008 valid  input  1  producer asserts while data holds a word to send.
REQ-009 ready  output  1  high when the block can accept a word.
REQ-010 tx  output  1  serial line; idle high, LSB first.
REQ-011 busy  output  1  high while a frame is pending or on the line.

Function
REQ-012 The block SHALL be a state machine with states IDLE, SYNC, START, DATA, PAR, STOP.
REQ-013 ready SHALL be high exactly when state is IDLE; busy SHALL equal not ready.
REQ-014 A handshake SHALL occur on a clock edge where valid and ready are both high; data SHALL be latched into a shift register and state SHALL go to SYNC.
REQ-015 cke in the same cycle as the handshake SHALL be ignored; SYNC waits for the next cke.
REQ-016 In SYNC with cke high, tx SHALL go 0 at that edge and state SHALL go to START.
REQ-017 In START with cke high, tx SHALL take shift bit 0, the bit counter SHALL clear, and state SHALL go to DATA.
REQ-018 In DATA with cke high: if bit counter < DATA_BITS-1, shift right, output next bit, increment counter; else go to PAR (PARITY != 0) driving the parity bit, or go to STOP driving tx=1.
REQ-019 Parity bit SHALL be XOR of all latched payload bits (even) or its inverse (odd), computed from the latched word, not live data.
REQ-020 In PAR with cke high, tx SHALL go 1, and state SHALL go to STOP with the stop counter cleared.
REQ-021 In STOP with cke high: if stop counter = STOP_BITS-1, go to IDLE; else increment the stop counter. tx SHALL remain 1 throughout.
REQ-022 Each line symbol SHALL last exactly one cke period; tx SHALL be registered (glitch-free).
REQ-023 Without cke the state SHALL hold indefinitely; no timeout.
REQ-024 valid and data changes outside IDLE SHALL have no effect on the frame in flight.
REQ-025 Back-to-back: valid held high SHALL be accepted on the first cycle ready returns high; minimum frame-to-frame gap is one cke period (SYNC).
REQ-026 Counters SHALL be sized $clog2 of their terminal count plus one and never wrap during a frame.

Reset
REQ-027 While rst_ is low: state IDLE, tx=1, ready=1, busy=0, shift register, bit and stop counters 0.
REQ-028 Reset asserted mid-frame SHALL abort immediately (asynchronously) with tx=1; no partial frame resumes after release.
REQ-029 First handshake SHALL be possible on the first rising clk edge after rst_ deasserts.

Verification
REQ-030 Defaults, cke every 4 cycles, send 0xA5 -> tx symbols 0,1,0,1,0,0,1,0,1,1 each 4 cycles; ready low from handshake until STOP ends.
REQ-031 PARITY=1, DATA_BITS=8, send 0x07 -> parity bit 1 after data; PARITY=2 same word -> parity bit 0.
REQ-032 STOP_BITS=2, valid held high with 0x55 then 0xAA -> two stop periods, then one SYNC period, then start bit of 0xAA; both words transmitted intact.
REQ-033 Handshake coincident with cke -> start bit begins at the following cke, not the coincident one.
REQ-034 rst_ low during DATA bit 3 -> tx=1, ready=1 same cycle; after release, new word 0x3C transmits correctly.
REQ-035 cke held low 100 cycles mid-DATA -> tx and state frozen; frame completes normally once cke resumes.
